// File: rtl/fifo_arb_pkg.sv
// Shared FSM state type and default sizing for the FIFO write arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int    DEF_CLIENTS       = 4;
   localparam int    DEF_DATA_WIDTH    = 8;
   localparam int    DEF_MAX_BURST     = 4;
   localparam string DEF_INSTANCE_NAME = "DEADF1F0";

endpackage

// File: rtl/arbiter_rr_pick.sv
// Round-robin search: first set request bit strictly after last_idx, wrapping.
// Purely combinational; last_idx itself is the lowest priority candidate.
module arbiter_rr_pick #(
   parameter int CLIENTS = 4
) (
   input  logic [CLIENTS-1:0]         req,
   input  logic [$clog2(CLIENTS)-1:0] last_idx,
   output logic [$clog2(CLIENTS)-1:0] pick,
   output logic                       found
);

   localparam int IDW = $clog2(CLIENTS);

   int idx;

   always_comb begin
      pick  = last_idx;
      found = 1'b0;
      idx   = 0;
      for (int i = 1; i <= CLIENTS; i++) begin
         idx = (int'(last_idx) + i) % CLIENTS;
         if (!found && req[idx]) begin
            pick  = IDW'(idx);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding one FIFO write port; grant one cycle after request.
// Ready to the granted client is !i_fifo_full; almost-full only blocks new grants.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int    CLIENTS       = DEF_CLIENTS,
   parameter int    DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int    MAX_BURST     = DEF_MAX_BURST,
   parameter string INSTANCE_NAME = DEF_INSTANCE_NAME
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic [CLIENTS-1:0]              i_req_valid,
   input  logic [CLIENTS*DATA_WIDTH-1:0]   i_req_data,
   input  logic [CLIENTS-1:0]              i_req_last,
   output logic [CLIENTS-1:0]              o_req_ready,
   output logic                            o_fifo_write,
   output logic [DATA_WIDTH-1:0]           o_fifo_wr_data,
   input  logic                            i_fifo_full,
   input  logic                            i_fifo_almost_full,
   output logic                            o_grant_valid,
   output logic [$clog2(CLIENTS)-1:0]      o_grant_id,
   output logic [$clog2(MAX_BURST+1)-1:0]  o_burst_count
);

   localparam int IDW = $clog2(CLIENTS);
   localparam int CW  = $clog2(MAX_BURST + 1);

   arb_state_t     state, state_nxt;
   logic [IDW-1:0] r_last_grant, r_grant, pick;
   logic [CW-1:0]  r_count;
   logic           r_miss;
   logic           found, req_g, last_g, beat, issue;

   arbiter_rr_pick #(.CLIENTS(CLIENTS)) u_pick (
      .req      (i_req_valid),
      .last_idx (r_last_grant),
      .pick     (pick),
      .found    (found)
   );

   assign req_g  = i_req_valid[r_grant];
   assign last_g = i_req_last[r_grant];
   assign beat   = (state == BURST) && req_g && !i_fifo_full;
   assign issue  = (state == IDLE) && found && !i_fifo_almost_full;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (issue) state_nxt = BURST;
         // r_miss marks the previous cycle as valid-low; a second one abandons.
         BURST: if ((beat && (last_g || r_count == CW'(MAX_BURST - 1))) ||
                    (!req_g && r_miss))
                   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_last_grant <= IDW'(CLIENTS - 1);
         r_grant      <= '0;
         r_count      <= '0;
         r_miss       <= 1'b0;
      end else if (issue) begin
         r_last_grant <= pick;
         r_grant      <= pick;
         r_count      <= '0;
         r_miss       <= 1'b0;
      end else if (state == BURST) begin
         r_miss <= !req_g;
         if (beat && r_count != CW'(MAX_BURST))
            r_count <= r_count + CW'(1);
      end
   end

   always_comb begin
      o_req_ready    = '0;
      o_fifo_wr_data = '0;
      for (int k = 0; k < CLIENTS; k++) begin
         if (state == BURST && IDW'(k) == r_grant) begin
            o_req_ready[k] = !i_fifo_full;
            o_fifo_wr_data = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign o_fifo_write  = beat;
   assign o_grant_valid = (state == BURST);
   assign o_grant_id    = r_grant;
   assign o_burst_count = r_count;

`ifndef SYNTHESIS
   a_no_write_full: assert property (@(posedge i_clk) disable iff (i_rst)
      !(o_fifo_write && i_fifo_full))
      else $error("%s: FIFO write while full", INSTANCE_NAME);
   a_one_ready: assert property (@(posedge i_clk) disable iff (i_rst)
      $onehot0(o_req_ready))
      else $error("%s: more than one ready bit high", INSTANCE_NAME);
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

   localparam int CLIENTS = 4;
   localparam int DW      = 8;
   localparam int MB      = 4;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [3:0]  i_req_valid = '0;
   logic [31:0] i_req_data  = '0;
   logic [3:0]  i_req_last  = '0;
   logic [3:0]  o_req_ready;
   logic        o_fifo_write;
   logic [7:0]  o_fifo_wr_data;
   logic        i_fifo_full = 1'b0;
   logic        i_fifo_almost_full = 1'b0;
   logic        o_grant_valid;
   logic [1:0]  o_grant_id;
   logic [2:0]  o_burst_count;

   fifo_wr_arbiter #(
      .CLIENTS(CLIENTS), .DATA_WIDTH(DW), .MAX_BURST(MB), .INSTANCE_NAME("DEADF1F0")
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_req_valid(i_req_valid), .i_req_data(i_req_data), .i_req_last(i_req_last),
      .o_req_ready(o_req_ready), .o_fifo_write(o_fifo_write), .o_fifo_wr_data(o_fifo_wr_data),
      .i_fifo_full(i_fifo_full), .i_fifo_almost_full(i_fifo_almost_full),
      .o_grant_valid(o_grant_valid), .o_grant_id(o_grant_id), .o_burst_count(o_burst_count)
   );

   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad   = 0;

   // Per-client beat stores {last, data}; expected writes {id, data} in order.
   logic [8:0] cmem [4][32];
   int         chead [4];
   int         ctail [4];
   logic [9:0] exp_q [$];

   int grant_log [$];
   int burst_log [$];
   int hi_log    [$];
   int gap_log   [$];
   int beats = 0, hi = 0, idle = 0;
   bit prev_gv = 1'b0, seen = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add_beat(input int c, input logic [7:0] d, input bit last, input bit wr);
      cmem[c][ctail[c]] = {last, d};
      ctail[c]++;
      if (wr) exp_q.push_back({2'(c), d});
   endtask

   function automatic bit clients_idle();
      for (int c = 0; c < 4; c++)
         if (chead[c] != ctail[c]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic clear_logs();
      grant_log.delete(); burst_log.delete(); hi_log.delete(); gap_log.delete();
      seen = 1'b0;
      idle = 0;
   endtask

   task automatic check_log(input string name, input int kind, input int n, input int e[5]);
      int q[$];
      case (kind)
         0:       q = grant_log;
         1:       q = burst_log;
         2:       q = hi_log;
         default: q = gap_log;
      endcase
      check({name, "_len"}, q.size(), n);
      for (int i = 0; i < n && i < q.size(); i++) check(name, q[i], e[i]);
   endtask

   task automatic wait_done(input string name, input int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge i_clk);
         #3;
         if (exp_q.size() == 0 && clients_idle() && !o_grant_valid) done = 1'b1;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: pending writes %0d, required 0", name, exp_q.size());
      end
   endtask

   task automatic wait_count2(input string name);
      bit hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(negedge i_clk);
         if (o_grant_valid && o_burst_count == 3'd2) hit = 1'b1;
      end
      if (!hit) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: burst count %0d, required 2", name, o_burst_count);
      end
   endtask

   // Client model: present head beat at negedge, retire it if accepted.
   initial begin
      for (int c = 0; c < 4; c++) begin
         chead[c] = 0;
         ctail[c] = 0;
      end
      forever begin
         @(negedge i_clk);
         for (int c = 0; c < 4; c++) begin
            if (chead[c] < ctail[c]) begin
               i_req_valid[c]        = 1'b1;
               i_req_data[c*8 +: 8]  = cmem[c][chead[c]][7:0];
               i_req_last[c]         = cmem[c][chead[c]][8];
            end else begin
               i_req_valid[c]        = 1'b0;
               i_req_data[c*8 +: 8]  = 8'h00;
               i_req_last[c]         = 1'b0;
            end
         end
         #1;
         for (int c = 0; c < 4; c++)
            if (i_req_valid[c] && o_req_ready[c]) chead[c]++;
      end
   end

   // Monitor: scoreboard pops on every FIFO write and logs grant/burst shape.
   initial begin
      logic [9:0] e;
      forever begin
         @(negedge i_clk);
         #2;
         if (o_grant_valid && !prev_gv) begin
            grant_log.push_back(int'(o_grant_id));
            if (seen) gap_log.push_back(idle);
            beats = 0;
            hi    = 0;
         end
         if (o_grant_valid) hi++;
         if (o_fifo_write) begin
            check("wr_while_full", int'(i_fifo_full), 0);
            check("beat_count", int'(o_burst_count), beats);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: data %0h id %0d, required no write",
                        o_fifo_wr_data, o_grant_id);
            end else begin
               e = exp_q.pop_front();
               check("wr_data", int'(o_fifo_wr_data), int'(e[7:0]));
               check("wr_id", int'(o_grant_id), int'(e[9:8]));
            end
            beats++;
         end
         if (!o_grant_valid && prev_gv) begin
            burst_log.push_back(beats);
            hi_log.push_back(hi);
            seen = 1'b1;
            idle = 0;
         end
         if (!o_grant_valid) idle++;
         prev_gv = o_grant_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge i_clk);
      #2;
      check("rst_ready", int'(o_req_ready), 0);
      check("rst_write", int'(o_fifo_write), 0);
      check("rst_data", int'(o_fifo_wr_data), 0);
      check("rst_gvalid", int'(o_grant_valid), 0);
      check("rst_gid", int'(o_grant_id), 0);
      check("rst_count", int'(o_burst_count), 0);
      @(negedge i_clk);
      i_rst = 1'b0;

      // Four clients, two-beat bursts; client 0 returns after the wrap.
      add_beat(0, 8'h00, 0, 1); add_beat(0, 8'h01, 1, 1);
      add_beat(1, 8'h10, 0, 1); add_beat(1, 8'h11, 1, 1);
      add_beat(2, 8'h20, 0, 1); add_beat(2, 8'h21, 1, 1);
      add_beat(3, 8'h30, 0, 1); add_beat(3, 8'h31, 1, 1);
      add_beat(0, 8'h02, 0, 1); add_beat(0, 8'h03, 1, 1);
      wait_done("s1", 200);
      check_log("s1_grant", 0, 5, '{0, 1, 2, 3, 0});
      check_log("s1_beats", 1, 5, '{2, 2, 2, 2, 2});
      check_log("s1_hold",  2, 5, '{2, 2, 2, 2, 2});
      check_log("s1_gap",   3, 4, '{1, 1, 1, 1, 0});
      clear_logs();

      // Client 2 streams 10 beats without last.
      for (int b = 0; b < 10; b++) add_beat(2, 8'(8'h40 + b), 0, 1);
      wait_done("s2", 200);
      check_log("s2_grant", 0, 3, '{2, 2, 2, 0, 0});
      check_log("s2_beats", 1, 3, '{4, 4, 2, 0, 0});
      check_log("s2_hold",  2, 3, '{4, 4, 4, 0, 0});
      check_log("s2_gap",   3, 2, '{1, 1, 0, 0, 0});
      clear_logs();

      // FIFO full for three cycles mid-burst.
      add_beat(1, 8'h50, 0, 1); add_beat(1, 8'h51, 0, 1);
      add_beat(1, 8'h52, 0, 1); add_beat(1, 8'h53, 1, 1);
      wait_count2("s3");
      i_fifo_full = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #2;
         check("s3_ready", int'(o_req_ready), 0);
         check("s3_write", int'(o_fifo_write), 0);
         check("s3_count", int'(o_burst_count), 2);
         @(negedge i_clk);
      end
      i_fifo_full = 1'b0;
      wait_done("s3", 200);
      check_log("s3_grant", 0, 1, '{1, 0, 0, 0, 0});
      check_log("s3_beats", 1, 1, '{4, 0, 0, 0, 0});
      check_log("s3_hold",  2, 1, '{7, 0, 0, 0, 0});
      clear_logs();

      // Almost-full holds off a new grant; grant follows one cycle after release.
      @(negedge i_clk);
      i_fifo_almost_full = 1'b1;
      add_beat(1, 8'h60, 0, 1); add_beat(1, 8'h61, 1, 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge i_clk);
         #2;
         check("s4_hold_gvalid", int'(o_grant_valid), 0);
      end
      @(negedge i_clk);
      i_fifo_almost_full = 1'b0;
      #2;
      check("s4_drop_gvalid", int'(o_grant_valid), 0);
      @(negedge i_clk);
      #2;
      check("s4_grant_gvalid", int'(o_grant_valid), 1);
      check("s4_grant_id", int'(o_grant_id), 1);
      wait_done("s4", 200);
      check_log("s4_beats", 1, 1, '{2, 0, 0, 0, 0});
      clear_logs();

      // Only client 3 requesting, twice: re-grant after wrap-around.
      add_beat(3, 8'h70, 1, 1); add_beat(3, 8'h71, 1, 1);
      wait_done("s5", 200);
      check_log("s5_grant", 0, 2, '{3, 3, 0, 0, 0});
      check_log("s5_beats", 1, 2, '{1, 1, 0, 0, 0});
      check_log("s5_gap",   3, 1, '{1, 0, 0, 0, 0});
      clear_logs();

      // Reset mid-burst at count 2, then priority restarts at client 0.
      add_beat(2, 8'h80, 0, 1); add_beat(2, 8'h81, 0, 1);
      add_beat(2, 8'h82, 0, 0); add_beat(2, 8'h83, 0, 0);
      wait_count2("s6");
      i_rst = 1'b1;
      #1;
      check("s6_ready", int'(o_req_ready), 0);
      check("s6_write", int'(o_fifo_write), 0);
      check("s6_data", int'(o_fifo_wr_data), 0);
      check("s6_gvalid", int'(o_grant_valid), 0);
      check("s6_gid", int'(o_grant_id), 0);
      check("s6_count", int'(o_burst_count), 0);
      check("s6_pending", exp_q.size(), 0);
      chead[2] = ctail[2];
      repeat (2) @(negedge i_clk);
      clear_logs();
      i_rst = 1'b0;
      add_beat(0, 8'h90, 1, 1);
      add_beat(3, 8'hA0, 1, 1);
      wait_done("s6", 200);
      check_log("s6_grant", 0, 2, '{0, 3, 0, 0, 0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
